// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection.
// Flush and load-use both insert an all-zero bubble; ext_stall freezes the whole stage.
module id_ex_stage #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] id_pc,
  input  logic [N-1:0] id_rs1_data,
  input  logic [N-1:0] id_rs2_data,
  input  logic [N-1:0] id_imm,
  input  logic [4:0]   id_rs1,
  input  logic [4:0]   id_rs2,
  input  logic [4:0]   id_rd,
  input  logic         id_valid,
  input  logic         id_reg_write,
  input  logic         id_mem_to_reg,
  input  logic         id_branch,
  input  logic         id_mem_read,
  input  logic         id_mem_write,
  input  logic         id_alu_src,
  input  logic [1:0]   id_alu_op,
  input  logic [3:0]   id_alu_func,
  input  logic         flush,
  input  logic         ext_stall,
  output logic [N-1:0] ex_pc,
  output logic [N-1:0] ex_rs1_data,
  output logic [N-1:0] ex_rs2_data,
  output logic [N-1:0] ex_imm,
  output logic [4:0]   ex_rs1,
  output logic [4:0]   ex_rs2,
  output logic [4:0]   ex_rd,
  output logic         ex_valid,
  output logic         ex_reg_write,
  output logic         ex_mem_to_reg,
  output logic         ex_branch,
  output logic         ex_mem_read,
  output logic         ex_mem_write,
  output logic         ex_alu_src,
  output logic [1:0]   ex_alu_op,
  output logic [3:0]   ex_alu_func,
  output logic         hazard_stall
);

  typedef struct packed {
    logic [N-1:0] pc;
    logic [N-1:0] rs1_data;
    logic [N-1:0] rs2_data;
    logic [N-1:0] imm;
    logic [4:0]   rs1;
    logic [4:0]   rs2;
    logic [4:0]   rd;
    logic         valid;
    logic         reg_write;
    logic         mem_to_reg;
    logic         branch;
    logic         mem_read;
    logic         mem_write;
    logic         alu_src;
    logic [1:0]   alu_op;
    logic [3:0]   alu_func;
  } stage_t;

  stage_t stage_q, stage_d;
  logic   lu;

  // A load to x0 never produces a value, so it cannot create a dependency.
  assign lu = stage_q.valid & stage_q.mem_read & (stage_q.rd != 5'd0) & id_valid &
              ((stage_q.rd == id_rs1) | (stage_q.rd == id_rs2));

  assign hazard_stall = lu & ~flush & ~ext_stall;

  always_comb begin
    stage_d = stage_q;
    if (flush) begin
      stage_d = '0;
    end else if (ext_stall) begin
      stage_d = stage_q;
    end else if (lu) begin
      stage_d = '0;
    end else begin
      stage_d.pc         = id_pc;
      stage_d.rs1_data   = id_rs1_data;
      stage_d.rs2_data   = id_rs2_data;
      stage_d.imm        = id_imm;
      stage_d.rs1        = id_rs1;
      stage_d.rs2        = id_rs2;
      stage_d.rd         = id_rd;
      stage_d.valid      = id_valid;
      stage_d.reg_write  = id_valid & id_reg_write;
      stage_d.mem_to_reg = id_valid & id_mem_to_reg;
      stage_d.branch     = id_valid & id_branch;
      stage_d.mem_read   = id_valid & id_mem_read;
      stage_d.mem_write  = id_valid & id_mem_write;
      stage_d.alu_src    = id_valid & id_alu_src;
      stage_d.alu_op     = id_valid ? id_alu_op : 2'b00;
      stage_d.alu_func   = id_valid ? id_alu_func : 4'b0000;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage_q <= '0;
    end else begin
      stage_q <= stage_d;
    end
  end

  assign ex_pc         = stage_q.pc;
  assign ex_rs1_data   = stage_q.rs1_data;
  assign ex_rs2_data   = stage_q.rs2_data;
  assign ex_imm        = stage_q.imm;
  assign ex_rs1        = stage_q.rs1;
  assign ex_rs2        = stage_q.rs2;
  assign ex_rd         = stage_q.rd;
  assign ex_valid      = stage_q.valid;
  assign ex_reg_write  = stage_q.reg_write;
  assign ex_mem_to_reg = stage_q.mem_to_reg;
  assign ex_branch     = stage_q.branch;
  assign ex_mem_read   = stage_q.mem_read;
  assign ex_mem_write  = stage_q.mem_write;
  assign ex_alu_src    = stage_q.alu_src;
  assign ex_alu_op     = stage_q.alu_op;
  assign ex_alu_func   = stage_q.alu_func;

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed scenarios plus randomized traffic
// compared against a rule-level model of the ID/EX register.
module tb_id_ex_stage;

  localparam int N = 32;

  typedef struct packed {
    logic [N-1:0] pc;
    logic [N-1:0] rs1_data;
    logic [N-1:0] rs2_data;
    logic [N-1:0] imm;
    logic [4:0]   rs1;
    logic [4:0]   rs2;
    logic [4:0]   rd;
    logic         valid;
    logic         reg_write;
    logic         mem_to_reg;
    logic         branch;
    logic         mem_read;
    logic         mem_write;
    logic         alu_src;
    logic [1:0]   alu_op;
    logic [3:0]   alu_func;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [N-1:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
  logic [4:0]   id_rs1, id_rs2, id_rd;
  logic         id_valid, id_reg_write, id_mem_to_reg, id_branch;
  logic         id_mem_read, id_mem_write, id_alu_src;
  logic [1:0]   id_alu_op;
  logic [3:0]   id_alu_func;
  logic         flush, ext_stall;
  logic [N-1:0] ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
  logic [4:0]   ex_rs1, ex_rs2, ex_rd;
  logic         ex_valid, ex_reg_write, ex_mem_to_reg, ex_branch;
  logic         ex_mem_read, ex_mem_write, ex_alu_src;
  logic [1:0]   ex_alu_op;
  logic [3:0]   ex_alu_func;
  logic         hazard_stall;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  exp_t        m;

  id_ex_stage #(.N(N)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_pc(id_pc), .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .id_valid(id_valid),
    .id_reg_write(id_reg_write), .id_mem_to_reg(id_mem_to_reg), .id_branch(id_branch),
    .id_mem_read(id_mem_read), .id_mem_write(id_mem_write), .id_alu_src(id_alu_src),
    .id_alu_op(id_alu_op), .id_alu_func(id_alu_func),
    .flush(flush), .ext_stall(ext_stall),
    .ex_pc(ex_pc), .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data), .ex_imm(ex_imm),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_valid(ex_valid),
    .ex_reg_write(ex_reg_write), .ex_mem_to_reg(ex_mem_to_reg), .ex_branch(ex_branch),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .ex_alu_src(ex_alu_src),
    .ex_alu_op(ex_alu_op), .ex_alu_func(ex_alu_func),
    .hazard_stall(hazard_stall)
  );

  always #5 clk = ~clk;

  function automatic exp_t dut_now();
    exp_t d;
    d.pc = ex_pc;       d.rs1_data = ex_rs1_data; d.rs2_data = ex_rs2_data; d.imm = ex_imm;
    d.rs1 = ex_rs1;     d.rs2 = ex_rs2;           d.rd = ex_rd;             d.valid = ex_valid;
    d.reg_write = ex_reg_write; d.mem_to_reg = ex_mem_to_reg; d.branch = ex_branch;
    d.mem_read = ex_mem_read;   d.mem_write = ex_mem_write;   d.alu_src = ex_alu_src;
    d.alu_op = ex_alu_op;       d.alu_func = ex_alu_func;
    return d;
  endfunction

  // Consumer reads a register that the in-flight load (non-x0) is still fetching.
  function automatic logic model_lu();
    return (m.valid === 1'b1) && (m.mem_read === 1'b1) && (m.rd != 5'd0) &&
           (id_valid === 1'b1) && ((m.rd == id_rs1) || (m.rd == id_rs2));
  endfunction

  function automatic logic model_hz();
    return model_lu() && !flush && !ext_stall;
  endfunction

  task automatic idle_inputs();
    id_pc = '0; id_rs1_data = '0; id_rs2_data = '0; id_imm = '0;
    id_rs1 = '0; id_rs2 = '0; id_rd = '0; id_valid = 1'b0;
    id_reg_write = 1'b0; id_mem_to_reg = 1'b0; id_branch = 1'b0;
    id_mem_read = 1'b0; id_mem_write = 1'b0; id_alu_src = 1'b0;
    id_alu_op = 2'b00; id_alu_func = 4'b0000; flush = 1'b0; ext_stall = 1'b0;
  endtask

  task automatic random_payload();
    id_pc = $urandom; id_rs1_data = $urandom; id_rs2_data = $urandom; id_imm = $urandom;
    id_reg_write = 1'($urandom); id_mem_to_reg = 1'($urandom); id_branch = 1'($urandom);
    id_mem_write = 1'($urandom); id_alu_src = 1'($urandom);
    id_alu_op = 2'($urandom_range(0, 2)); id_alu_func = 4'($urandom);
  endtask

  // Advance one clock; the model applies the edge rules to the inputs seen before the edge.
  task automatic cycle();
    exp_t nxt;
    if (flush) nxt = '0;
    else if (ext_stall) nxt = m;
    else if (model_lu()) nxt = '0;
    else begin
      nxt.pc = id_pc; nxt.rs1_data = id_rs1_data; nxt.rs2_data = id_rs2_data; nxt.imm = id_imm;
      nxt.rs1 = id_rs1; nxt.rs2 = id_rs2; nxt.rd = id_rd; nxt.valid = id_valid;
      nxt.reg_write  = id_valid && id_reg_write;
      nxt.mem_to_reg = id_valid && id_mem_to_reg;
      nxt.branch     = id_valid && id_branch;
      nxt.mem_read   = id_valid && id_mem_read;
      nxt.mem_write  = id_valid && id_mem_write;
      nxt.alu_src    = id_valid && id_alu_src;
      nxt.alu_op     = id_valid ? id_alu_op : 2'b00;
      nxt.alu_func   = id_valid ? id_alu_func : 4'b0000;
    end
    @(posedge clk);
    #1;
    m = nxt;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle_inputs();
    random_payload();
    id_valid = 1'b1; id_mem_read = 1'b1; id_rd = 5'd3; id_rs1 = 5'd3;
    m = '0;
    repeat (3) @(posedge clk);
    #2;
    n_checks++;
    if (dut_now() !== m) begin
      n_fail++; $display("FAIL reset_state: got %h expected %h", dut_now(), m);
    end
    n_checks++;
    if (hazard_stall !== 1'b0) begin
      n_fail++; $display("FAIL reset_hazard: got %b expected 0", hazard_stall);
    end
    rst_n = 1'b1;
    idle_inputs();
    #1;
  endtask

  task automatic test_rtype();
    random_payload();
    id_valid = 1'b1; id_alu_op = 2'b10; id_alu_func = 4'b1000; id_rd = 5'd5;
    id_rs1 = 5'd1; id_rs2 = 5'd2;
    cycle();
    n_checks++;
    if ({ex_alu_op, ex_alu_func, ex_rd, ex_valid} !== {2'b10, 4'b1000, 5'd5, 1'b1}) begin
      n_fail++;
      $display("FAIL rtype_fields: got op=%b func=%b rd=%0d v=%b expected op=10 func=1000 rd=5 v=1",
               ex_alu_op, ex_alu_func, ex_rd, ex_valid);
    end
    n_checks++;
    if (dut_now() !== m) begin
      n_fail++; $display("FAIL rtype_full: got %h expected %h", dut_now(), m);
    end
  endtask

  task automatic test_load_use();
    idle_inputs();
    random_payload();
    id_valid = 1'b1; id_mem_read = 1'b1; id_mem_to_reg = 1'b1; id_reg_write = 1'b1;
    id_mem_write = 1'b0; id_rd = 5'd7; id_rs1 = 5'd2; id_rs2 = 5'd0;
    cycle();
    random_payload();
    id_valid = 1'b1; id_mem_read = 1'b0; id_rs1 = 5'd3; id_rs2 = 5'd7; id_rd = 5'd9;
    #1;
    n_checks++;
    if (hazard_stall !== 1'b1) begin
      n_fail++; $display("FAIL lu_hazard: got %b expected 1", hazard_stall);
    end
    cycle();
    n_checks++;
    if (dut_now() !== exp_t'('0)) begin
      n_fail++; $display("FAIL lu_bubble: got %h expected all zero", dut_now());
    end
    n_checks++;
    if (hazard_stall !== 1'b0) begin
      n_fail++; $display("FAIL lu_no_restall: got %b expected 0", hazard_stall);
    end
    cycle();
    n_checks++;
    if ({ex_valid, ex_rs2, ex_rd} !== {1'b1, 5'd7, 5'd9} || dut_now() !== m) begin
      n_fail++; $display("FAIL lu_consumer: got %h expected %h", dut_now(), m);
    end
  endtask

  task automatic test_x0_load();
    idle_inputs();
    random_payload();
    id_valid = 1'b1; id_mem_read = 1'b1; id_rd = 5'd0; id_rs1 = 5'd4;
    cycle();
    random_payload();
    id_valid = 1'b1; id_mem_read = 1'b0; id_rs1 = 5'd0; id_rs2 = 5'd0; id_rd = 5'd12;
    #1;
    n_checks++;
    if (hazard_stall !== 1'b0) begin
      n_fail++; $display("FAIL x0_hazard: got %b expected 0", hazard_stall);
    end
    cycle();
    n_checks++;
    if (ex_valid !== 1'b1 || ex_rd !== 5'd12 || dut_now() !== m) begin
      n_fail++; $display("FAIL x0_capture: got %h expected %h", dut_now(), m);
    end
  endtask

  task automatic test_flush_all();
    idle_inputs();
    random_payload();
    id_valid = 1'b1; id_mem_read = 1'b1; id_rd = 5'd11;
    cycle();
    random_payload();
    id_valid = 1'b1; id_rs1 = 5'd11; flush = 1'b1; ext_stall = 1'b1;
    #1;
    n_checks++;
    if (hazard_stall !== 1'b0) begin
      n_fail++; $display("FAIL flush_all_hazard: got %b expected 0", hazard_stall);
    end
    cycle();
    n_checks++;
    if (ex_valid !== 1'b0 || dut_now() !== exp_t'('0)) begin
      n_fail++; $display("FAIL flush_all_bubble: got %h expected all zero", dut_now());
    end
    idle_inputs();
  endtask

  task automatic test_ext_stall_hold();
    exp_t held;
    idle_inputs();
    random_payload();
    id_valid = 1'b1; id_rd = 5'd20; id_rs1 = 5'd21; id_rs2 = 5'd22;
    cycle();
    held = m;
    for (int i = 0; i < 3; i++) begin
      random_payload();
      id_valid = 1'b1; id_rd = 5'(i + 1); id_rs1 = 5'(i + 2); ext_stall = 1'b1;
      cycle();
      n_checks++;
      if (dut_now() !== held) begin
        n_fail++; $display("FAIL ext_stall_hold[%0d]: got %h expected %h", i, dut_now(), held);
      end
    end
    idle_inputs();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      random_payload();
      id_valid    = ($urandom_range(0, 9) != 0);
      id_mem_read = ($urandom_range(0, 9) < 4);
      id_rd       = 5'($urandom_range(0, 3));
      id_rs1      = 5'($urandom_range(0, 3));
      id_rs2      = 5'($urandom_range(0, 4));
      flush       = ($urandom_range(0, 9) == 0);
      ext_stall   = ($urandom_range(0, 19) < 3);
      #1;
      n_checks++;
      if (hazard_stall !== model_hz()) begin
        n_fail++; $display("FAIL rand_hazard[%0d]: got %b expected %b", i, hazard_stall, model_hz());
      end
      cycle();
      n_checks++;
      if (dut_now() !== m) begin
        n_fail++; $display("FAIL rand_state[%0d]: got %h expected %h", i, dut_now(), m);
      end
      n_checks++;
      if (!ex_valid && (ex_mem_write || ex_reg_write)) begin
        n_fail++; $display("FAIL rand_bubble_writes[%0d]: got mw=%b rw=%b expected 0 with ex_valid=0",
                           i, ex_mem_write, ex_reg_write);
      end
    end
    idle_inputs();
  endtask

  task automatic test_async_reset();
    idle_inputs();
    random_payload();
    id_valid = 1'b1; id_reg_write = 1'b1; id_mem_read = 1'b1; id_rd = 5'd6;
    cycle();
    n_checks++;
    if (ex_valid !== 1'b1 || ex_reg_write !== 1'b1) begin
      n_fail++; $display("FAIL areset_setup: got v=%b rw=%b expected 1 1", ex_valid, ex_reg_write);
    end
    id_rs1 = 5'd6;
    #2;
    rst_n = 1'b0;
    #1;
    m = '0;
    n_checks++;
    if (dut_now() !== m) begin
      n_fail++; $display("FAIL areset_immediate: got %h expected all zero", dut_now());
    end
    n_checks++;
    if (hazard_stall !== 1'b0) begin
      n_fail++; $display("FAIL areset_hazard: got %b expected 0", hazard_stall);
    end
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    random_payload();
    id_valid = 1'b1; id_rd = 5'd15; id_rs1 = 5'd6; id_rs2 = 5'd6;
    cycle();
    n_checks++;
    if (ex_valid !== 1'b1 || ex_rd !== 5'd15 || dut_now() !== m) begin
      n_fail++; $display("FAIL areset_resume: got %h expected %h", dut_now(), m);
    end
  endtask

  task automatic test_invalid_capture();
    idle_inputs();
    random_payload();
    id_valid = 1'b0; id_reg_write = 1'b1; id_mem_write = 1'b1; id_alu_op = 2'b10;
    id_rd = 5'd17;
    cycle();
    n_checks++;
    if ({ex_valid, ex_reg_write, ex_mem_write, ex_alu_op} !== 5'b0 || dut_now() !== m) begin
      n_fail++; $display("FAIL invalid_capture: got %h expected %h", dut_now(), m);
    end
  endtask

  initial begin
    test_reset();
    test_rtype();
    test_load_use();
    test_x0_load();
    test_flush_all();
    test_ext_stall_hold();
    test_invalid_capture();
    test_random();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 SHALL have parameter N, default 32, datapath width of PC, register-data and immediate fields.
REQ-002 SHALL have port clk, input, 1, single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n, input, 1, reset, asynchronous and active-low.
REQ-004 SHALL have inputs id_pc, id_rs1_data, id_rs2_data and id_imm, each N bits, decode-stage PC, operands and sign-extended immediate.
REQ-005 SHALL have inputs id_rs1, id_rs2 and id_rd, each 5 bits, decode-stage register addresses.
REQ-006 SHALL have input id_valid, 1 bit, meaning the decode slot holds a real instruction.
REQ-007 SHALL have 1-bit control inputs id_reg_write, id_mem_to_reg, id_branch, id_mem_read, id_mem_write and id_alu_src.
REQ-008 SHALL have input id_alu_op, 2 bits, main-decoder ALU class (00 add, 01 sub/branch, 10 R-type).
REQ-009 SHALL have input id_alu_func, 4 bits, {funct7[5], funct3}, the field consumed by the ALU control unit.
REQ-010 SHALL have input flush, 1 bit, taken-branch/jump kill of the decode-slot instruction.
REQ-011 SHALL have input ext_stall, 1 bit, downstream freeze request (memory wait).
REQ-012 SHALL have registered outputs ex_pc, ex_rs1_data, ex_rs2_data, ex_imm (N bits), ex_rs1, ex_rs2, ex_rd (5 bits), ex_valid, the seven control outputs ex_* mirroring REQ-007/008, and ex_alu_func (4 bits).
REQ-013 SHALL have output hazard_stall, 1 bit, combinational, telling PC and IF/ID to hold.

Function
REQ-014 SHALL compute the load-use condition lu = ex_valid & ex_mem_read & (ex_rd != 0) & id_valid & ((ex_rd == id_rs1) | (ex_rd == id_rs2)).
REQ-015 SHALL drive hazard_stall = lu & ~flush & ~ext_stall.
REQ-016 SHALL resolve each edge with priority: flush > ext_stall > lu > normal capture.
REQ-017 On flush: SHALL load a bubble, i.e. ex_valid, ex_reg_write, ex_mem_to_reg, ex_branch, ex_mem_read, ex_mem_write, ex_alu_src = 0, ex_alu_op = 00 and ex_alu_func = 0000, regardless of ext_stall.
REQ-018 On ext_stall without flush: SHALL hold every output register unchanged.
REQ-019 On lu without flush/ext_stall: SHALL load a bubble per REQ-017; the decode instruction is re-presented next cycle by the held upstream stage.
REQ-020 Normal capture: SHALL copy every id_* input to its ex_* output in one cycle (latency 1); control fields are captured as 0 when id_valid = 0.
REQ-021 Bubble cycles: data/address fields (ex_pc, ex_*_data, ex_imm, ex_rs*, ex_rd) SHALL be zeroed so downstream comparators never match a bubble.
REQ-022 SHALL never drive ex_mem_write or ex_reg_write high while ex_valid = 0.
REQ-023 A load with ex_rd = x0 SHALL NOT raise hazard_stall.
REQ-024 After one lu bubble the same consumer SHALL NOT stall again (ex_mem_read now 0).

Reset
REQ-025 On rst_n low, asynchronously and independent of clk, every registered output SHALL go to 0 (pipeline empty, ex_valid = 0).
REQ-026 Reset released mid-operation SHALL resume normal capture at the first rising edge with rst_n high; no stale state survives.
REQ-027 hazard_stall SHALL read 0 throughout reset, since ex_valid = 0.

Verification
REQ-028 R-type capture: id_alu_op=10, id_alu_func=1000, id_rd=5, id_valid=1 -> next edge ex_alu_op=10, ex_alu_func=1000, ex_rd=5, ex_valid=1.
REQ-029 Load-use: ex holds lw with ex_rd=7; decode id_rs2=7 -> hazard_stall=1 same cycle; next edge ex_valid=0, all control 0; following edge captures the consumer with hazard_stall=0.
REQ-030 x0 load: ex_mem_read=1, ex_rd=0, id_rs1=0 -> hazard_stall=0, normal capture.
REQ-031 Simultaneous flush+ext_stall+lu -> hazard_stall=0, next edge bubble (ex_valid=0).
REQ-032 ext_stall held 3 cycles with changing id_* -> all ex_* outputs constant for those 3 edges.
REQ-033 rst_n pulsed low between edges while ex_valid=1, ex_reg_write=1 -> outputs 0 immediately, before the next clk edge.
